// File: rtl/sme_pkg.sv
// Shared character constants and FSM state type for the sme_param string matcher.
package sme_pkg;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/sme_param_if.sv
// Character-stream and result bundle between the host and sme_param.
interface sme_param_if #(
  parameter int CHAR_W = 8,
  parameter int IDX_W  = 5
);
  logic [CHAR_W-1:0] chardata;
  logic              isstring;
  logic              ispattern;
  logic              busy;
  logic              valid;
  logic              match;
  logic [IDX_W-1:0]  match_index;
  logic [IDX_W:0]    match_len;

  modport master (
    output chardata, isstring, ispattern,
    input  busy, valid, match, match_index, match_len
  );

  modport slave (
    input  chardata, isstring, ispattern,
    output busy, valid, match, match_index, match_len
  );
endinterface

// File: rtl/sme_char_cmp.sv
// Single-step comparator: one pattern character against the current string character.
// With SME_STAR_EN defined, '*' is reported as a zero-width match; otherwise it is a literal.
module sme_char_cmp
  import sme_pkg::*;
#(
  parameter int CHAR_W = 8
) (
  input  logic [CHAR_W-1:0] pat_ch_i,
  input  logic [CHAR_W-1:0] str_ch_i,
  input  logic              eos_i,
  input  logic              pos0_i,
  output logic              match_o,
  output logic              consume_o,
  output logic              skip_o
);

  // Decode the pattern character into match / consume / anchor-skip flags.
  always_comb begin
    match_o   = 1'b0;
    consume_o = 1'b0;
    skip_o    = 1'b0;
    case (pat_ch_i)
      CHAR_W'(CH_CARET): begin
        if (pos0_i) begin
          match_o = 1'b1;
        end else if (!eos_i && (str_ch_i == CHAR_W'(CH_SPACE))) begin
          match_o   = 1'b1;
          consume_o = 1'b1;
          skip_o    = 1'b1;
        end else begin
          match_o = 1'b0;
        end
      end
      CHAR_W'(CH_DOLLAR): begin
        match_o = eos_i || (str_ch_i == CHAR_W'(CH_SPACE));
      end
      CHAR_W'(CH_DOT): begin
        match_o   = !eos_i;
        consume_o = 1'b1;
      end
`ifdef SME_STAR_EN
      CHAR_W'(CH_STAR): begin
        match_o = 1'b1;
      end
`endif
      default: begin
        match_o   = !eos_i && (str_ch_i == pat_ch_i);
        consume_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sme_param.sv
// Parametrised string-matching engine: buffers a string and a pattern, then reports the leftmost match.
// Define SME_STAR_EN to make '*' a backtracking wildcard; otherwise '*' is a literal.
module sme_param
  import sme_pkg::*;
#(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int CHAR_W  = 8,
  parameter int IDX_W   = $clog2(STR_MAX)
) (
  input logic        clk,
  input logic        reset,
  sme_param_if.slave bus
);

  localparam int LW = IDX_W + 1;
  localparam int PA = $clog2(PAT_MAX);
  localparam int PW = PA + 1;

  state_e            state_q, state_d;
  logic [CHAR_W-1:0] str_mem_q [STR_MAX];
  logic [CHAR_W-1:0] pat_mem_q [PAT_MAX];
  logic [LW-1:0]     str_len_q, str_len_d;
  logic [PW-1:0]     pat_len_q, pat_len_d;
  logic              str_fresh_q, str_fresh_d;
  logic              pat_fresh_q, pat_fresh_d;
  logic              pat_seen_q, pat_seen_d;
  logic [LW-1:0]     s_q, s_d, i_q, i_d, idx_q, idx_d;
  logic [PW-1:0]     p_q, p_d;
  logic              match_q, match_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [LW-1:0]     len_q, len_d;
`ifdef SME_STAR_EN
  logic              star_v_q, star_v_d;
  logic [PW-1:0]     star_p_q, star_p_d;
  logic [LW-1:0]     star_i_q, star_i_d;
  logic              is_star_s;
`endif

  logic              str_we_s, pat_we_s;
  logic [LW-1:0]     str_waddr_s;
  logic [PW-1:0]     pat_waddr_s;
  logic [CHAR_W-1:0] pat_ch_s, str_ch_s;
  logic              eos_s, lit_s;
  logic              cmp_match_s, cmp_consume_s, cmp_skip_s;
  logic              step_match_s, step_consume_s, step_skip_s;
  logic              next_start_s, fail_s;

  // Fetch the characters under the pattern and string cursors; out-of-range reads yield zero.
  always_comb begin
    pat_ch_s = '0;
    str_ch_s = '0;
    if (p_q < pat_len_q) begin
      pat_ch_s = pat_mem_q[p_q[PA-1:0]];
    end else begin
      pat_ch_s = '0;
    end
    if (i_q < str_len_q) begin
      str_ch_s = str_mem_q[i_q[IDX_W-1:0]];
    end else begin
      str_ch_s = '0;
    end
  end

  assign eos_s = (i_q == str_len_q);
  // Anchors away from their positions degrade to ordinary literals.
  assign lit_s = ((pat_ch_s == CHAR_W'(CH_CARET)) && (p_q != '0)) ||
                 ((pat_ch_s == CHAR_W'(CH_DOLLAR)) && (p_q != (pat_len_q - PW'(1))));
`ifdef SME_STAR_EN
  assign is_star_s = (pat_ch_s == CHAR_W'(CH_STAR));
`endif

  sme_char_cmp #(.CHAR_W(CHAR_W)) u_cmp (
    .pat_ch_i  (pat_ch_s),
    .str_ch_i  (str_ch_s),
    .eos_i     (eos_s),
    .pos0_i    (i_q == '0),
    .match_o   (cmp_match_s),
    .consume_o (cmp_consume_s),
    .skip_o    (cmp_skip_s)
  );

  assign step_match_s   = lit_s ? (!eos_s && (str_ch_s == pat_ch_s)) : cmp_match_s;
  assign step_consume_s = lit_s ? 1'b1 : cmp_consume_s;
  assign step_skip_s    = lit_s ? 1'b0 : cmp_skip_s;

  // Next-state logic: loading, one comparison step per SEARCH cycle, result capture.
  always_comb begin
    state_d      = state_q;
    str_len_d    = str_len_q;
    pat_len_d    = pat_len_q;
    str_fresh_d  = str_fresh_q;
    pat_fresh_d  = pat_fresh_q;
    pat_seen_d   = pat_seen_q;
    s_d          = s_q;
    i_d          = i_q;
    idx_d        = idx_q;
    p_d          = p_q;
    match_d      = match_q;
    index_d      = index_q;
    len_d        = len_q;
    str_we_s     = 1'b0;
    pat_we_s     = 1'b0;
    str_waddr_s  = str_fresh_q ? '0 : str_len_q;
    pat_waddr_s  = pat_fresh_q ? '0 : pat_len_q;
    next_start_s = 1'b0;
    fail_s       = 1'b0;
`ifdef SME_STAR_EN
    star_v_d     = star_v_q;
    star_p_d     = star_p_q;
    star_i_d     = star_i_q;
`endif
    case (state_q)
      LOAD: begin
        if (bus.isstring) begin
          str_fresh_d = 1'b0;
          if (str_waddr_s < LW'(STR_MAX)) begin
            str_we_s  = 1'b1;
            str_len_d = str_waddr_s + LW'(1);
          end else begin
            str_len_d = str_waddr_s;
          end
        end else if (bus.ispattern) begin
          pat_fresh_d = 1'b0;
          pat_seen_d  = 1'b1;
          if (pat_waddr_s < PW'(PAT_MAX)) begin
            pat_we_s  = 1'b1;
            pat_len_d = pat_waddr_s + PW'(1);
          end else begin
            pat_len_d = pat_waddr_s;
          end
        end else if (pat_seen_q) begin
          state_d = SEARCH;
          s_d     = '0;
          i_d     = '0;
          idx_d   = '0;
          p_d     = '0;
`ifdef SME_STAR_EN
          star_v_d = 1'b0;
`endif
        end else begin
          state_d = LOAD;
        end
      end
      SEARCH: begin
        if (str_len_q == '0) begin
          fail_s = 1'b1;
        end else if (p_q == pat_len_q) begin
          state_d = DONE;
          match_d = 1'b1;
          index_d = idx_q[IDX_W-1:0];
          len_d   = i_q - idx_q;
        end else if (step_match_s) begin
          p_d   = p_q + PW'(1);
          i_d   = step_consume_s ? (i_q + LW'(1)) : i_q;
          idx_d = step_skip_s ? (i_q + LW'(1)) : idx_q;
`ifdef SME_STAR_EN
          if (is_star_s) begin
            star_v_d = 1'b1;
            star_p_d = p_q;
            star_i_d = i_q;
          end else begin
            star_v_d = star_v_q;
          end
`endif
        end else begin
`ifdef SME_STAR_EN
          // Backtrack: let the last star swallow one more character.
          if (star_v_q && (star_i_q < str_len_q)) begin
            star_i_d = star_i_q + LW'(1);
            i_d      = star_i_q + LW'(1);
            p_d      = star_p_q + PW'(1);
          end else begin
            next_start_s = 1'b1;
          end
`else
          next_start_s = 1'b1;
`endif
        end
        if (next_start_s) begin
          if ((s_q + LW'(1)) >= str_len_q) begin
            fail_s = 1'b1;
          end else begin
            s_d   = s_q + LW'(1);
            i_d   = s_q + LW'(1);
            idx_d = s_q + LW'(1);
            p_d   = '0;
`ifdef SME_STAR_EN
            star_v_d = 1'b0;
`endif
          end
        end else begin
          s_d = s_q;
        end
        if (fail_s) begin
          state_d = DONE;
          match_d = 1'b0;
          index_d = '0;
          len_d   = '0;
        end else begin
          match_d = match_d;
        end
      end
      DONE: begin
        state_d     = LOAD;
        str_fresh_d = 1'b1;
        pat_fresh_d = 1'b1;
        pat_seen_d  = 1'b0;
        match_d     = 1'b0;
        index_d     = '0;
        len_d       = '0;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD;
      str_len_q   <= '0;
      pat_len_q   <= '0;
      str_fresh_q <= 1'b1;
      pat_fresh_q <= 1'b1;
      pat_seen_q  <= 1'b0;
      s_q         <= '0;
      i_q         <= '0;
      idx_q       <= '0;
      p_q         <= '0;
      match_q     <= 1'b0;
      index_q     <= '0;
      len_q       <= '0;
`ifdef SME_STAR_EN
      star_v_q    <= 1'b0;
      star_p_q    <= '0;
      star_i_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      str_len_q   <= str_len_d;
      pat_len_q   <= pat_len_d;
      str_fresh_q <= str_fresh_d;
      pat_fresh_q <= pat_fresh_d;
      pat_seen_q  <= pat_seen_d;
      s_q         <= s_d;
      i_q         <= i_d;
      idx_q       <= idx_d;
      p_q         <= p_d;
      match_q     <= match_d;
      index_q     <= index_d;
      len_q       <= len_d;
`ifdef SME_STAR_EN
      star_v_q    <= star_v_d;
      star_p_q    <= star_p_d;
      star_i_q    <= star_i_d;
`endif
    end
  end

  // Character buffers; contents are only meaningful up to the stored lengths.
  always_ff @(posedge clk) begin
    if (str_we_s) begin
      str_mem_q[str_waddr_s[IDX_W-1:0]] <= bus.chardata;
    end
    if (pat_we_s) begin
      pat_mem_q[pat_waddr_s[PA-1:0]] <= bus.chardata;
    end
  end

  assign bus.busy        = (state_q == SEARCH);
  assign bus.valid       = (state_q == DONE);
  assign bus.match       = match_q;
  assign bus.match_index = index_q;
  assign bus.match_len   = len_q;

endmodule

// File: tb/tb_sme_param.sv
// Scoreboard bench for sme_param; expectations adapt to SME_STAR_EN.
module tb_sme_param;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int BUDGET  = STR_MAX * (STR_MAX + 1) + 40;

  typedef struct packed {
    logic       m;
    logic [4:0] idx;
    logic [5:0] len;
  } exp_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];

  sme_param_if #(.CHAR_W(8), .IDX_W(5)) bus ();

  sme_param #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .CHAR_W(8), .IDX_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic m, input int idx, input int len);
    exp_t e;
    e.m   = m;
    e.idx = idx[4:0];
    e.len = len[5:0];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string s, input bit is_str);
    for (int k = 0; k < s.len(); k++) begin
      bus.chardata  = s[k];
      bus.isstring  = is_str;
      bus.ispattern = !is_str;
      tick();
    end
    bus.isstring  = 1'b0;
    bus.ispattern = 1'b0;
  endtask

  task automatic wait_result(input string name, input bit junk);
    int   n;
    exp_t e;
    exp_t g;
    n = 0;
    tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_rise: got %b expected 1", name, bus.busy);
    end
    while (bus.valid !== 1'b1 && n < BUDGET) begin
      if (junk && bus.busy === 1'b1) begin
        bus.chardata  = 8'h78;
        bus.isstring  = n[0];
        bus.ispattern = ~n[0];
      end else begin
        bus.isstring  = 1'b0;
        bus.ispattern = 1'b0;
      end
      tick();
      n++;
    end
    bus.isstring  = 1'b0;
    bus.ispattern = 1'b0;
    e = sb.pop_front();
    g = {bus.match, bus.match_index, bus.match_len};
    checks++;
    if (bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: no valid within %0d cycles", name, BUDGET);
    end else if (g !== e || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got m=%0b idx=%0d len=%0d busy=%b, expected m=%0b idx=%0d len=%0d busy=0",
               name, g.m, g.idx, g.len, bus.busy, e.m, e.idx, e.len);
    end
    tick();
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL %s valid_pulse: got %b expected 0", name, bus.valid);
    end
  endtask

  task automatic run(input string name, input string s, input string p, input exp_t e, input bit junk);
    if (s.len() != 0) send(s, 1'b1);
    send(p, 1'b0);
    sb.push_back(e);
    wait_result(name, junk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.chardata  = 8'h00;
    bus.isstring  = 1'b0;
    bus.ispattern = 1'b0;
    repeat (2) tick();
    checks++;
    if ({bus.busy, bus.valid, bus.match, bus.match_index, bus.match_len} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b valid=%b m=%b idx=%0d len=%0d expected all 0",
               bus.busy, bus.valid, bus.match, bus.match_index, bus.match_len);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_literal();
    run("wor", "hello world", "wor", mk(1'b1, 6, 3), 1'b0);
    run("dot", "", "o.w", mk(1'b1, 4, 3), 1'b0);
  endtask

  task automatic test_caret();
    run("caret_space", "", "^wor", mk(1'b1, 6, 3), 1'b0);
    run("caret_fail", "", "^orl", mk(1'b0, 0, 0), 1'b0);
    run("caret_pos0", "", "^hel", mk(1'b1, 0, 3), 1'b0);
  endtask

  task automatic test_back_to_back();
    run("b2b_first", "", "l", mk(1'b1, 2, 1), 1'b0);
    run("b2b_second", "", "ld", mk(1'b1, 9, 2), 1'b0);
  endtask

  task automatic test_dollar();
    run("dollar_space", "ab cd", "b$", mk(1'b1, 1, 1), 1'b0);
    run("dollar_fail", "", "a$", mk(1'b0, 0, 0), 1'b0);
    run("dollar_eos", "", "d$", mk(1'b1, 4, 1), 1'b0);
    run("pat_reload", "", "c.", mk(1'b1, 3, 2), 1'b0);
  endtask

  task automatic test_busy_ignore();
    run("busy_search", "ab cd", "d", mk(1'b1, 4, 1), 1'b1);
    run("busy_kept", "", "c.", mk(1'b1, 3, 2), 1'b0);
  endtask

  task automatic test_star();
`ifdef SME_STAR_EN
    run("star_backtrack", "aXbYbc", "a*bc", mk(1'b1, 0, 6), 1'b0);
    run("star_trailing", "", "a*", mk(1'b1, 0, 1), 1'b0);
`else
    run("star_literal", "aXbYbc", "a*bc", mk(1'b0, 0, 0), 1'b0);
    run("star_trailing", "", "a*", mk(1'b0, 0, 0), 1'b0);
`endif
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 40; k++) begin
      bus.chardata = (k < 31) ? 8'h61 : ((k == 31) ? 8'h62 : 8'h7A);
      bus.isstring = 1'b1;
      tick();
    end
    bus.isstring = 1'b0;
    run("ovf_dropped", "", "z", mk(1'b0, 0, 0), 1'b0);
    run("ovf_last", "", "b$", mk(1'b1, 31, 1), 1'b0);
`ifdef SME_STAR_EN
    run("ovf_fulllen", "", "a*b", mk(1'b1, 0, 32), 1'b0);
`else
    run("ovf_fulllen", "", "a*b", mk(1'b0, 0, 0), 1'b0);
`endif
  endtask

  task automatic test_reset_mid_search();
    int bad;
    bad = 0;
    send("q", 1'b0);
    tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy: got %b expected 1", bus.busy);
    end
    repeat (5) tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.valid, bus.match, bus.match_index, bus.match_len} !== 14'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got busy=%b valid=%b m=%b idx=%0d len=%0d expected all 0",
               bus.busy, bus.valid, bus.match, bus.match_index, bus.match_len);
    end
    tick();
    reset = 1'b0;
    repeat (40) begin
      tick();
      if ({bus.busy, bus.valid, bus.match, bus.match_index, bus.match_len} !== 14'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midrst_quiet: got %0d active cycles expected 0", bad);
    end
    run("empty_string", "", "a", mk(1'b0, 0, 0), 1'b0);
  endtask

  initial begin
    test_reset();
    test_literal();
    test_caret();
    test_back_to_back();
    test_dollar();
    test_busy_ignore();
    test_star();
    test_overflow();
    test_reset_mid_search();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
